// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared encodings for the sprite game: direction codes,
//                colour constants, datapath FSM states and a width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Direction request encoding from the keyboard decode
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // 3-bit RGB colours understood by the VGA adapter
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

    // Datapath sequencing states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_ERASE = 3'd4
    } state_t;

    // Counter width for a count of v items; never narrower than one bit
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/box_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : box_sweeper
//  Description : Plots a SPRITE_W x SPRITE_H box one pixel per cycle in
//                row-major order (x offset innermost). Origin and colour are
//                latched on start; pixel outputs are registered, so each pixel
//                appears one cycle after its offset-counter value.
//  Revision    : 1.0 - initial release
// ============================================================================
module box_sweeper
    import game_pkg::*;
#(
    parameter int              SPRITE_W    = 4,
    parameter int              SPRITE_H    = 4,
    parameter int              XW          = 8,
    parameter int              YW          = 7,
    parameter int              COLOR_BITS  = 3,
    parameter logic [COLOR_BITS-1:0] IDLE_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [XW-1:0]         org_x_i,
    input  logic [YW-1:0]         org_y_i,
    input  logic [COLOR_BITS-1:0] color_i,
    output logic [XW-1:0]         pix_x_o,
    output logic [YW-1:0]         pix_y_o,
    output logic [COLOR_BITS-1:0] pix_color_o,
    output logic                  plot_o,
    output logic                  done_o
);

    localparam int OXW = clog2_min1(SPRITE_W);
    localparam int OYW = clog2_min1(SPRITE_H);
    localparam logic [OXW-1:0] OX_LAST = OXW'(SPRITE_W - 1);
    localparam logic [OYW-1:0] OY_LAST = OYW'(SPRITE_H - 1);

    logic                  active_q;
    logic [OXW-1:0]        ox_q;
    logic [OYW-1:0]        oy_q;
    logic [XW-1:0]         org_x_q;
    logic [YW-1:0]         org_y_q;
    logic [COLOR_BITS-1:0] color_q;
    logic [XW-1:0]         pix_x_q;
    logic [YW-1:0]         pix_y_q;
    logic [COLOR_BITS-1:0] pix_color_q;
    logic                  plot_q;
    logic                  done_q;
    logic                  last_w;

    assign last_w = active_q && (ox_q == OX_LAST) && (oy_q == OY_LAST);

    // Offset counters plus registered pixel outputs; done rides with the last plot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            org_x_q     <= '0;
            org_y_q     <= '0;
            color_q     <= IDLE_COLOR;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= IDLE_COLOR;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            plot_q <= active_q;
            done_q <= last_w;
            if (active_q) begin
                pix_x_q     <= org_x_q + XW'(ox_q);
                pix_y_q     <= org_y_q + YW'(oy_q);
                pix_color_q <= color_q;
            end
            if (start_i) begin
                active_q <= 1'b1;
                ox_q     <= '0;
                oy_q     <= '0;
                org_x_q  <= org_x_i;
                org_y_q  <= org_y_i;
                color_q  <= color_i;
            end else if (active_q) begin
                if (ox_q == OX_LAST) begin
                    ox_q <= '0;
                    if (oy_q == OY_LAST) begin
                        active_q <= 1'b0;
                    end else begin
                        oy_q <= oy_q + OYW'(1);
                    end
                end else begin
                    ox_q <= ox_q + OXW'(1);
                end
            end
        end
    end

    assign pix_x_o     = pix_x_q;
    assign pix_y_o     = pix_y_q;
    assign pix_color_o = pix_color_q;
    assign plot_o      = plot_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: rtl/sprite_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_datapath
//  Description : Player sprite position, direction-request latch and frame
//                timer. Each legal move erases the old box and redraws the
//                new one through box_sweeper onto the VGA pixel interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_datapath
    import game_pkg::*;
#(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int SPRITE_W    = 4,
    parameter int SPRITE_H    = 4,
    parameter int COLOR_BITS  = 3,
    parameter logic [COLOR_BITS-1:0] FG_COLOR = 3'b100,
    parameter logic [COLOR_BITS-1:0] BG_COLOR = 3'b000,
    parameter int INIT_X      = 80,
    parameter int INIT_Y      = 100,
    parameter int TICK_CYCLES = 2**19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dir_valid,
    input  logic [1:0]            dir,
    output logic [XW-1:0]         vga_x,
    output logic [YW-1:0]         vga_y,
    output logic [COLOR_BITS-1:0] vga_color,
    output logic                  vga_plot,
    output logic [XW-1:0]         xpos,
    output logic [YW-1:0]         ypos,
    output logic                  busy,
    output logic                  tick
);

    localparam int            TW        = clog2_min1(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [XW:0]   X_LIMIT   = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]   Y_LIMIT   = (YW+1)'(SCREEN_H);

    state_t         state_q, state_d;
    logic [XW-1:0]  xpos_q, xpos_d;
    logic [YW-1:0]  ypos_q, ypos_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           tick_q, tick_d;
    logic           pend_valid_q, pend_valid_d;
    logic [1:0]     pend_dir_q, pend_dir_d;
    logic [1:0]     move_dir_q, move_dir_d;

    logic                  sweep_start;
    logic [COLOR_BITS-1:0] sweep_color;
    logic                  sweep_done;
    logic                  legal;
    logic [XW:0]           x_right_edge;
    logic [YW:0]           y_bottom_edge;

    // Edge sums one bit wider so a sprite touching the border cannot wrap
    assign x_right_edge  = {1'b0, xpos_q} + (XW+1)'(SPRITE_W);
    assign y_bottom_edge = {1'b0, ypos_q} + (YW+1)'(SPRITE_H);

    // Whether the pending direction keeps the whole box on screen
    always_comb begin
        legal = 1'b0;
        case (pend_dir_q)
            DIR_UP:    legal = (ypos_q != '0);
            DIR_DOWN:  legal = (y_bottom_edge < Y_LIMIT);
            DIR_LEFT:  legal = (xpos_q != '0);
            default:   legal = (x_right_edge < X_LIMIT);
        endcase
    end

    // State, position, timer and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            xpos_q       <= XW'(INIT_X);
            ypos_q       <= YW'(INIT_Y);
            timer_q      <= '0;
            tick_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
            move_dir_q   <= DIR_UP;
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            timer_q      <= timer_d;
            tick_q       <= tick_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            move_dir_q   <= move_dir_d;
        end
    end

    // Next-state logic; a new request is applied after CHECK consumes the old one
    always_comb begin
        state_d      = state_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        timer_d      = timer_q;
        tick_d       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        move_dir_d   = move_dir_q;
        sweep_start  = 1'b0;
        sweep_color  = FG_COLOR;

        case (state_q)
            ST_INIT: begin
                sweep_start = 1'b1;
                state_d     = ST_DRAW;
            end
            ST_DRAW: begin
                if (sweep_done) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_q == TICK_LAST) begin
                    tick_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_CHECK;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_WAIT;
                if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    if (legal) begin
                        move_dir_d  = pend_dir_q;
                        sweep_start = 1'b1;
                        sweep_color = BG_COLOR;
                        state_d     = ST_ERASE;
                    end
                end
            end
            ST_ERASE: begin
                if (sweep_done) begin
                    case (move_dir_q)
                        DIR_UP:   ypos_d = ypos_q - YW'(1);
                        DIR_DOWN: ypos_d = ypos_q + YW'(1);
                        DIR_LEFT: xpos_d = xpos_q - XW'(1);
                        default:  xpos_d = xpos_q + XW'(1);
                    endcase
                    sweep_start = 1'b1;
                    state_d     = ST_DRAW;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (dir_valid) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dir;
        end
    end

    // Origin is the next-state position so the redraw after ERASE uses the moved box
    box_sweeper #(
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .XW         (XW),
        .YW         (YW),
        .COLOR_BITS (COLOR_BITS),
        .IDLE_COLOR (BG_COLOR)
    ) u_sweeper (
        .clk         (clk),
        .rst         (reset),
        .start_i     (sweep_start),
        .org_x_i     (xpos_d),
        .org_y_i     (ypos_d),
        .color_i     (sweep_color),
        .pix_x_o     (vga_x),
        .pix_y_o     (vga_y),
        .pix_color_o (vga_color),
        .plot_o      (vga_plot),
        .done_o      (sweep_done)
    );

    assign busy = vga_plot;
    assign tick = tick_q;
    assign xpos = xpos_q;
    assign ypos = ypos_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_datapath
//  Description : Directed bench for sprite_datapath (4x4 sprite, 8-cycle
//                tick). Instance A starts at (80,100); instance B starts at
//                (80,116) for the bottom-edge case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_datapath;
    import game_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b, dv_a, dv_b;
    logic [1:0] dir_a, dir_b;
    logic [7:0] a_x, a_xpos, b_x, b_xpos;
    logic [6:0] a_y, a_ypos, b_y, b_ypos;
    logic [2:0] a_col, b_col;
    logic       a_plot, a_busy, a_tick, b_plot, b_busy, b_tick;

    sprite_datapath #(.SPRITE_W(4), .SPRITE_H(4), .TICK_CYCLES(8)) u_dut_a (
        .clk(clk), .reset(reset_a), .dir_valid(dv_a), .dir(dir_a),
        .vga_x(a_x), .vga_y(a_y), .vga_color(a_col), .vga_plot(a_plot),
        .xpos(a_xpos), .ypos(a_ypos), .busy(a_busy), .tick(a_tick)
    );

    sprite_datapath #(.SPRITE_W(4), .SPRITE_H(4), .TICK_CYCLES(8), .INIT_Y(116)) u_dut_b (
        .clk(clk), .reset(reset_b), .dir_valid(dv_b), .dir(dir_b),
        .vga_x(b_x), .vga_y(b_y), .vga_color(b_col), .vga_plot(b_plot),
        .xpos(b_xpos), .ypos(b_ypos), .busy(b_busy), .tick(b_tick)
    );

    typedef struct {int x; int y; int c; int t;} pix_t;
    typedef struct {logic [1:0] d; int ex; int ey; int eplots;} vec_t;

    pix_t qa[$];
    int   nplot_b  = 0;
    int   busy_err = 0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   last_tick_cyc = 0;
    int   cur_x, cur_y;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel capture and busy/plot agreement, sampled mid-cycle
    always @(negedge clk) begin
        if (a_plot) qa.push_back('{int'(a_x), int'(a_y), int'(a_col), cyc});
        if (b_plot) nplot_b++;
        if (a_busy !== a_plot || b_busy !== b_plot) busy_err++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wait_tick(input bit sel);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel ? b_tick : a_tick) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: got no tick expected tick within 300 cycles (sel=%0d)", sel);
        end
        last_tick_cyc = cyc;
    endtask

    task automatic request(input bit sel, input logic [1:0] d);
        if (sel) begin dv_b = 1'b1; dir_b = d; end
        else     begin dv_a = 1'b1; dir_a = d; end
        @(negedge clk);
        dv_a = 1'b0;
        dv_b = 1'b0;
    endtask

    // Compare 16 captured pixels from index base against a box at (x0,y0)
    task automatic check_sweep(input int base, input int x0, input int y0, input int c);
        for (int oy = 0; oy < 4; oy++) begin
            for (int ox = 0; ox < 4; ox++) begin
                int idx = base + oy * 4 + ox;
                if (idx < qa.size()) begin
                    chk("sweep_x", qa[idx].x, x0 + ox);
                    chk("sweep_y", qa[idx].y, y0 + oy);
                    chk("sweep_color", qa[idx].c, c);
                end else begin
                    chk("sweep_missing_pixel", qa.size(), idx + 1);
                end
            end
        end
        if (base + 15 < qa.size())
            chk("sweep_consecutive", qa[base+15].t - qa[base].t, 15);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{DIR_RIGHT, 81, 100, 32};
        vecs[1] = '{DIR_DOWN,  81, 101, 32};
        vecs[2] = '{DIR_LEFT,  80, 101, 32};
        vecs[3] = '{DIR_UP,    80, 100, 32};
        vecs[4] = '{DIR_RIGHT, 81, 100, 32};
        vecs[5] = '{DIR_LEFT,  80, 100, 32};

        reset_a = 1'b1; reset_b = 1'b1;
        dv_a = 1'b0; dv_b = 1'b0; dir_a = 2'd0; dir_b = 2'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_vga_x", int'(a_x), 0);
        chk("rst_vga_y", int'(a_y), 0);
        chk("rst_vga_color", int'(a_col), 0);
        chk("rst_vga_plot", int'(a_plot), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_tick", int'(a_tick), 0);
        chk("rst_xpos", int'(a_xpos), 80);
        chk("rst_ypos", int'(a_ypos), 100);

        // Initial draw and first tick spacing
        qa.delete();
        reset_a = 1'b0;
        wait_tick(0);
        chk("init_plot_count", qa.size(), 16);
        check_sweep(0, 80, 100, 4);
        if (qa.size() >= 16) chk("first_tick_gap", last_tick_cyc - qa[15].t, 9);
        else                 chk("first_tick_gap_no_plots", qa.size(), 16);

        // Table of single moves
        cur_x = 80; cur_y = 100;
        foreach (vecs[i]) begin
            repeat (2) @(negedge clk);
            request(0, vecs[i].d);
            wait_tick(0);
            qa.delete();
            wait_tick(0);
            chk("vec_xpos", int'(a_xpos), vecs[i].ex);
            chk("vec_ypos", int'(a_ypos), vecs[i].ey);
            chk("vec_plots", qa.size(), vecs[i].eplots);
            if (vecs[i].eplots == 32) begin
                check_sweep(0, cur_x, cur_y, 0);
                check_sweep(16, vecs[i].ex, vecs[i].ey, 4);
            end
            cur_x = vecs[i].ex; cur_y = vecs[i].ey;
        end

        // Latest request wins: left then up before one tick
        repeat (2) @(negedge clk);
        request(0, DIR_LEFT);
        request(0, DIR_UP);
        wait_tick(0);
        qa.delete();
        wait_tick(0);
        chk("two_req_xpos", int'(a_xpos), 80);
        chk("two_req_ypos", int'(a_ypos), 99);
        chk("two_req_plots", qa.size(), 32);
        check_sweep(16, 80, 99, 4);

        // Request on the CHECK-consume cycle survives to the following tick
        repeat (2) @(negedge clk);
        request(0, DIR_RIGHT);
        wait_tick(0);
        qa.delete();
        request(0, DIR_DOWN);
        wait_tick(0);
        chk("consume_xpos", int'(a_xpos), 81);
        chk("consume_ypos", int'(a_ypos), 99);
        qa.delete();
        wait_tick(0);
        chk("late_req_xpos", int'(a_xpos), 81);
        chk("late_req_ypos", int'(a_ypos), 100);
        chk("late_req_plots", qa.size(), 32);

        // Reset asserted on the 7th erase pixel
        repeat (2) @(negedge clk);
        request(0, DIR_RIGHT);
        wait_tick(0);
        begin
            int n = 0;
            for (int i = 0; i < 60 && n < 7; i++) begin
                @(negedge clk);
                if (a_plot) n++;
            end
            chk("erase_reached_7th", n, 7);
        end
        reset_a = 1'b1;
        #1;
        chk("midrst_plot", int'(a_plot), 0);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_xpos", int'(a_xpos), 80);
        repeat (2) @(negedge clk);
        qa.delete();
        reset_a = 1'b0;
        wait_tick(0);
        chk("redraw_plots", qa.size(), 16);
        check_sweep(0, 80, 100, 4);
        chk("redraw_xpos", int'(a_xpos), 80);
        chk("redraw_ypos", int'(a_ypos), 100);

        // Held left request walks to the left edge and stops there
        repeat (2) @(negedge clk);
        dv_a = 1'b1; dir_a = DIR_LEFT;
        for (int k = 1; k <= 81; k++) begin
            wait_tick(0);
            chk("left_walk_xpos", int'(a_xpos), 81 - k);
        end
        qa.delete();
        repeat (3) wait_tick(0);
        chk("left_edge_plots", qa.size(), 0);
        chk("left_edge_xpos", int'(a_xpos), 0);
        chk("left_edge_ypos", int'(a_ypos), 100);
        dv_a = 1'b0;

        // Bottom edge on instance B
        nplot_b = 0;
        reset_b = 1'b0;
        wait_tick(1);
        chk("b_init_plots", nplot_b, 16);
        chk("b_init_ypos", int'(b_ypos), 116);
        repeat (2) @(negedge clk);
        request(1, DIR_DOWN);
        wait_tick(1);
        nplot_b = 0;
        wait_tick(1);
        chk("b_down_plots", nplot_b, 0);
        chk("b_down_ypos", int'(b_ypos), 116);
        wait_tick(1);
        chk("b_pending_cleared_plots", nplot_b, 0);
        repeat (2) @(negedge clk);
        request(1, DIR_UP);
        wait_tick(1);
        nplot_b = 0;
        wait_tick(1);
        chk("b_up_plots", nplot_b, 32);
        chk("b_up_ypos", int'(b_ypos), 115);
        chk("b_up_xpos", int'(b_xpos), 80);

        chk("busy_eq_plot_errors", busy_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
